// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit.
// Multiply uses shift-add and divide uses restoring division. Each retires one
// bit per cycle over magnitudes, and sign correction is applied in a final FIX cycle.
// Optional feature macro: MDU_DIV_EN. When it is defined, the divider and the divide
// special cases are built. When it is undefined, every funct3[2]=1 op completes
// through the fast path with result 0.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    // Multiplicand for MUL*, divisor for DIV*/REM*
    logic [WIDTH-1:0]   addend_q, addend_d;
    // MUL*: {partial product, remaining multiplier bits}; DIV*: {unused, dividend->quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
`ifdef MDU_DIV_EN
    // The stored remainder is always < divisor, so WIDTH bits hold it. The
    // WIDTH+1-bit working value is rem_sh below.
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic [WIDTH-1:0]   quot, rem_s;
`endif

    logic               a_signed, b_signed, neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               fast;
    logic [WIDTH-1:0]   fast_res;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    // Decode operand signedness, magnitudes and fast-path cases from the live inputs
    always_comb begin
        a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
        neg_a    = a_signed & rs1_val[WIDTH-1];
        neg_b    = b_signed & rs2_val[WIDTH-1];
        mag_a    = neg_a ? -rs1_val : rs1_val;
        mag_b    = neg_b ? -rs2_val : rs2_val;
        fast     = 1'b0;
        fast_res = '0;
`ifdef MDU_DIV_EN
        if (funct3[2] && rs2_val == '0) begin
            fast     = 1'b1;
            fast_res = funct3[1] ? rs1_val : '1;
        end else if (funct3[2] && !funct3[0] && rs1_val == {1'b1, {(WIDTH-1){1'b0}}}
                     && rs2_val == '1) begin
            fast     = 1'b1;
            fast_res = funct3[1] ? '0 : rs1_val;
        end
`else
        if (funct3[2]) fast = 1'b1;
`endif
    end

    // FSM and datapath next-state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        addend_d = addend_q;
        acc_d    = acc_q;
        result_d = result_q;
        sum      = '0;
        prod     = '0;
`ifdef MDU_DIV_EN
        rem_d    = rem_q;
        rem_sh   = '0;
        rem_sub  = '0;
        quot     = '0;
        rem_s    = '0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    op_d     = funct3;
                    sign_a_d = neg_a;
                    sign_b_d = neg_b;
                    cnt_d    = '0;
`ifdef MDU_DIV_EN
                    if (funct3[2]) begin
                        acc_d    = {{WIDTH{1'b0}}, mag_a};
                        addend_d = mag_b;
                        rem_d    = '0;
                    end else
`endif
                    begin
                        acc_d    = {{WIDTH{1'b0}}, mag_b};
                        addend_d = mag_a;
                    end
                    if (fast) begin
                        state_d  = S_DONE;
                        result_d = fast_res;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
`ifdef MDU_DIV_EN
                if (op_q[2]) begin
                    // Restoring step: a clear borrow bit means the shifted remainder >= divisor
                    rem_sh  = {rem_q, acc_q[WIDTH-1]};
                    rem_sub = rem_sh - {1'b0, addend_q};
                    rem_d   = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
                    acc_d   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~rem_sub[WIDTH]};
                end else
`endif
                begin
                    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, addend_q} : '0);
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                prod    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
                if (op_q[2]) begin
`ifdef MDU_DIV_EN
                    quot     = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    rem_s    = sign_a_q ? -rem_q : rem_q;
                    result_d = op_q[1] ? rem_s : quot;
`else
                    result_d = '0;
`endif
                end else if (op_q[1:0] == 2'b00) begin
                    result_d = prod[WIDTH-1:0];
                end else begin
                    result_d = prod[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            addend_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
`ifdef MDU_DIV_EN
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            addend_q <= addend_d;
            acc_q    <= acc_d;
            result_q <= result_d;
`ifdef MDU_DIV_EN
            rem_q    <= rem_d;
`endif
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative RV32M multiply/divide unit for the RISC-V core. It takes the two operands read out of the register file (RD1/RD2) plus funct3 and computes over multiple clock cycles. It returns a 32-bit result that the control path steers to the register file write-data port (WD3), with WE3 held until `done`. A start/busy/done handshake lets the control FSM stall the PC while the unit works.

## Interface
- `WIDTH`, 32, operand/result width; the iteration count equals `WIDTH`.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `funct3`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val`  in  WIDTH  operand A (dividend/multiplicand), from regfile RD1.
- `rs2_val`  in  WIDTH  operand B (divisor/multiplier), from regfile RD2.
- `busy`  out  1  high in CALC and FIX.
- `done`  out  1  one-cycle pulse; high in DONE.
- `result`  out  WIDTH  registered result, valid when `done`=1, held until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE. On reset: state IDLE, `busy`=0, `done`=0, `result`=0, counter=0, internal regs=0.
- Accept: `start`=1 while in IDLE or DONE. The unit latches `funct3` and operands, and records sign flags per op. Signed operands: MUL*/DIV/REM signed; MULHSU A signed, B unsigned. It stores operand magnitudes and moves to CALC with counter=0.
- Fast path, evaluated at accept. The unit goes directly to DONE with `result` loaded at the accept edge:
  - divide by zero (B=0): DIV/DIVU → all ones; REM/REMU → A.
  - signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- CALC, multiply: shift-add over magnitudes, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- CALC, divide: restoring division, one quotient bit per cycle. It keeps a WIDTH+1-bit partial remainder.
- The counter increments each CALC cycle. When the counter reaches WIDTH−1, the next state is FIX.
- FIX, sign correction:
  - product negated if the sign flags differ;
  - quotient negated if the signs differ;
  - remainder takes the dividend's sign.
- FIX, result select: MUL → low WIDTH of product; MULH/MULHSU/MULHU → high WIDTH; DIV/DIVU → quotient; REM/REMU → remainder. `result` is registered and the next state is DONE.
- DONE lasts one cycle: `done`=1. It returns to IDLE, or re-accepts if `start`=1 (back-to-back).
- `start` while `busy`=1 is ignored; latched operands are unaffected by input changes during CALC/FIX.
- `rst` asserted mid-operation aborts immediately: outputs return to reset values and no `done` is produced.

## Timing
- Normal op: `start` sampled at edge k. CALC runs across edges k+1…k+32, FIX resolves at edge k+33, and `done`=1 during the cycle after edge k+33. Latency is 34 cycles; `busy`=1 after edges k…k+32.
- Fast path: `done`=1 during the cycle after edge k; `busy` stays 0.
- `result` changes only at the FIX→DONE edge or at a fast-path accept edge.
- Throughput: one op per 34 cycles, since a new `start` may coincide with `done`.

## Configuration
- `MDU_DIV_EN` defined: all eight funct3 ops supported as above.
- `MDU_DIV_EN` undefined:
  - the divider datapath and divide special cases are not compiled;
  - funct3[2]=1 takes the fast path with `result`=0 and `done` one cycle later;
  - MUL* behaviour and latency are unchanged.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD): `busy` for 33 cycles, then `done` with `result`=0xFFFFFFEB, 34 cycles after `start`.
- MULH/MULHU/MULHSU on A=0x80000000, B=0xFFFFFFFF: results 0x00000000 / 0x7FFFFFFF / 0x80000000.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with `done` one cycle after `start` and `busy` never high:
  - DIV 5/0 → 0xFFFFFFFF;
  - REMU 5/0 → 5;
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- `start` pulsed at cycle 10 of a running MUL, with operands changed: ignored, and the original result is delivered. `start` coincident with `done`: the new op is accepted with no idle cycle.
- `rst` asserted at CALC cycle 15: `busy`, `done` and `result` read 0 immediately, no `done` pulse follows, and a fresh op afterwards completes correctly.
